// File: rtl/axi_timed_throttle_rab.sv
// Transmit-side pacing stage for one valid/ready channel: small FIFO drained
// under a token-bucket rate limit plus a minimum idle gap after each handshake.
module axi_timed_throttle_rab #(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_TOKENS    = 4,
  parameter int REFILL_PERIOD = 8,
  parameter int MIN_GAP       = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  throttled_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(MAX_TOKENS + 1);
  localparam int GW = ($clog2(MIN_GAP + 1) > 1) ? $clog2(MIN_GAP + 1) : 1;
  localparam int RW = ($clog2(REFILL_PERIOD) > 1) ? $clog2(REFILL_PERIOD) : 1;

  logic [DATA_WIDTH-1:0] buffer_reg [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [TW-1:0]         tokens_reg;
  logic [GW-1:0]         gap_reg;
  logic [RW-1:0]         refill_reg;

  logic full;
  logic push;
  logic pop;
  logic refill;

  assign full        = (count_reg == CW'(FIFO_DEPTH));
  assign ready_out   = !full;
  assign push        = valid_in && !full;
  assign valid_out   = (count_reg != '0) && (tokens_reg != '0) && (gap_reg == '0);
  assign pop         = valid_out && ready_in;
  assign data_out    = buffer_reg[rd_ptr_reg];
  assign throttled_o = (count_reg != '0) && !valid_out;
  assign refill      = (refill_reg == RW'(REFILL_PERIOD - 1));

  // Each storage entry is its own register so it can be cleared by reset.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          buffer_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == AW'(gi))) begin
          buffer_reg[gi] <= data_in;
        end
      end
    end
  endgenerate

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gap_reg    <= '0;
      refill_reg <= '0;
      tokens_reg <= TW'(MAX_TOKENS);
    end else begin
      if (pop) begin
        gap_reg <= GW'(MIN_GAP);
      end else if (gap_reg != '0) begin
        gap_reg <= gap_reg - GW'(1);
      end

      refill_reg <= refill ? '0 : refill_reg + RW'(1);

      // A refill coinciding with a pop cancels out, keeping the bucket level.
      if (refill && !pop) begin
        if (tokens_reg != TW'(MAX_TOKENS)) tokens_reg <= tokens_reg + TW'(1);
      end else if (pop && !refill) begin
        tokens_reg <= tokens_reg - TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_timed_throttle_rab.sv
// Directed bench for axi_timed_throttle_rab with default parameters.
module tb_axi_timed_throttle_rab;

  logic        clk;
  logic        rstn;
  logic        valid_in;
  logic [31:0] data_in;
  logic        ready_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic        throttled_o;

  int total;
  int bad;

  axi_timed_throttle_rab dut (
    .clk        (clk),
    .rstn       (rstn),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .throttled_o(throttled_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves rstn released at a negedge; the following posedge is cycle 0.
  task automatic do_reset();
    rstn     = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    data_in  = 32'h0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    valid_in = 1'b1;
    ready_in = 1'b0;
    data_in  = $urandom;
    repeat (3) @(negedge clk);
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready_out got=%b exp=1", ready_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out got=%b exp=0", valid_out); end
    total++; if (throttled_o !== 1'b0) begin bad++; $display("FAIL reset_throttled got=%b exp=0", throttled_o); end
    total++; if (dut.count_reg !== 3'd0) begin bad++; $display("FAIL reset_no_push count=%0d exp=0", dut.count_reg); end
    total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
    $display("test_reset: done");
  endtask

  task automatic test_steady_stream();
    logic        pop;
    logic        push;
    logic        exp_pop;
    logic [31:0] pop_idx;
    do_reset();
    valid_in = 1'b1;
    ready_in = 1'b1;
    data_in  = 32'h0;
    pop_idx  = 32'h0;
    for (int cyc = 0; cyc < 26; cyc++) begin
      pop     = valid_out && ready_in;
      push    = valid_in && ready_out;
      exp_pop = (cyc inside {1, 3, 5, 7, 9, 16, 24});
      total++;
      if (pop !== exp_pop) begin bad++; $display("FAIL steady_pop cycle=%0d got=%b exp=%b", cyc, pop, exp_pop); end
      if (pop) begin
        total++;
        if (data_out !== pop_idx) begin bad++; $display("FAIL steady_data cycle=%0d got=%h exp=%h", cyc, data_out, pop_idx); end
        pop_idx++;
      end
      if (cyc >= 10 && !exp_pop) begin
        total++;
        if (throttled_o !== 1'b1) begin bad++; $display("FAIL steady_throttled cycle=%0d got=%b exp=1", cyc, throttled_o); end
      end
      $display("steady cycle=%0d pop=%b throttled=%b", cyc, pop, throttled_o);
      @(posedge clk);
      #1;
      if (push) data_in = data_in + 32'd1;
      @(negedge clk);
    end
    valid_in = 1'b0;
    ready_in = 1'b0;
  endtask

  task automatic test_fill_backpressure();
    int          idx;
    logic [31:0] exp;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      ready_in = 1'b0;
      valid_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
        data_in = 32'hA0 + 32'(p * 4 + i);
        @(negedge clk);
      end
      valid_in = 1'b0;
      total++;
      if (ready_out !== 1'b0) begin bad++; $display("FAIL fill_full_ready pass=%0d got=%b exp=0", p, ready_out); end
      ready_in = 1'b1;
      idx = 0;
      for (int t = 0; t < 80 && idx < 4; t++) begin
        if (valid_out) begin
          exp = 32'hA0 + 32'(p * 4 + idx);
          total++;
          if (data_out !== exp) begin bad++; $display("FAIL fill_order pass=%0d beat=%0d got=%h exp=%h", p, idx, data_out, exp); end
          $display("fill pass=%0d beat=%0d data=%h", p, idx, data_out);
          idx++;
        end
        @(negedge clk);
      end
      total++;
      if (idx != 4) begin bad++; $display("FAIL fill_drain_timeout pass=%0d got=%0d exp=4", p, idx); end
      ready_in = 1'b0;
    end
  endtask

  task automatic test_stall_stability();
    do_reset();
    ready_in = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'h55;
    @(negedge clk);
    data_in = 32'h56;
    @(negedge clk);
    valid_in = 1'b0;
    for (int c = 0; c < 20; c++) begin
      total++;
      if (valid_out !== 1'b1 || data_out !== 32'h55) begin
        bad++; $display("FAIL stall_hold cycle=%0d valid=%b data=%h exp valid=1 data=55", c, valid_out, data_out);
      end
      @(negedge clk);
    end
    total++;
    if (dut.tokens_reg !== 3'd4) begin bad++; $display("FAIL stall_tokens got=%0d exp=4", dut.tokens_reg); end
    $display("stall held 20 cycles tokens=%0d", dut.tokens_reg);
    ready_in = 1'b1;
    total++;
    if (valid_out !== 1'b1) begin bad++; $display("FAIL stall_release_pop got=%b exp=1", valid_out); end
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL stall_gap got=%b exp=0", valid_out); end
    @(negedge clk);
    total++;
    if (valid_out !== 1'b1 || data_out !== 32'h56) begin
      bad++; $display("FAIL stall_after_gap valid=%b data=%h exp valid=1 data=56", valid_out, data_out);
    end
    @(negedge clk);
    ready_in = 1'b0;
  endtask

  task automatic test_push_pop();
    logic [31:0] exp_q [$];
    do_reset();
    ready_in = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'hC0;
    @(negedge clk);
    data_in = 32'hC1;
    @(negedge clk);
    data_in  = 32'hC2;
    ready_in = 1'b1;
    total++;
    if (valid_out !== 1'b1 || data_out !== 32'hC0) begin
      bad++; $display("FAIL pp_simul_pop valid=%b data=%h exp valid=1 data=c0", valid_out, data_out);
    end
    @(negedge clk);
    ready_in = 1'b0;
    total++;
    if (dut.count_reg !== 3'd2) begin bad++; $display("FAIL pp_count_same got=%0d exp=2", dut.count_reg); end
    data_in = 32'hC3;
    @(negedge clk);
    data_in = 32'hC4;
    @(negedge clk);
    total++;
    if (ready_out !== 1'b0) begin bad++; $display("FAIL pp_full_ready got=%b exp=0", ready_out); end
    data_in  = 32'hEE;
    ready_in = 1'b1;
    total++;
    if (valid_out !== 1'b1 || data_out !== 32'hC1) begin
      bad++; $display("FAIL pp_full_pop valid=%b data=%h exp valid=1 data=c1", valid_out, data_out);
    end
    @(negedge clk);
    valid_in = 1'b0;
    total++;
    if (dut.count_reg !== 3'd3) begin bad++; $display("FAIL pp_full_refused count=%0d exp=3", dut.count_reg); end
    exp_q = '{32'hC2, 32'hC3, 32'hC4};
    for (int t = 0; t < 60 && exp_q.size() > 0; t++) begin
      if (valid_out) begin
        total++;
        if (data_out !== exp_q[0]) begin bad++; $display("FAIL pp_order got=%h exp=%h", data_out, exp_q[0]); end
        $display("pp pop data=%h", data_out);
        void'(exp_q.pop_front());
      end
      @(negedge clk);
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL pp_drain_timeout left=%0d exp=0", exp_q.size()); end
    repeat (3) @(negedge clk);
    total++;
    if (valid_out !== 1'b0 || dut.count_reg !== 3'd0) begin
      bad++; $display("FAIL pp_no_extra valid=%b count=%0d exp valid=0 count=0", valid_out, dut.count_reg);
    end
    ready_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready_in = 1'b0;
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 32'h11 * 32'(i + 1);
      @(negedge clk);
    end
    valid_in = 1'b0;
    total++;
    if (valid_out !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b exp=1", valid_out); end
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1 || throttled_o !== 1'b0) begin
      bad++; $display("FAIL mid_async valid=%b ready=%b thr=%b exp 0 1 0", valid_out, ready_out, throttled_o);
    end
    @(negedge clk);
    rstn = 1'b1;
    total++;
    if (dut.tokens_reg !== 3'd4 || dut.count_reg !== 3'd0) begin
      bad++; $display("FAIL mid_state tokens=%0d count=%0d exp 4 0", dut.tokens_reg, dut.count_reg);
    end
    data_in  = 32'hB0;
    valid_in = 1'b1;
    ready_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    total++;
    if (valid_out !== 1'b1 || data_out !== 32'hB0) begin
      bad++; $display("FAIL mid_next_beat valid=%b data=%h exp valid=1 data=b0", valid_out, data_out);
    end
    $display("reset_mid next beat data=%h", data_out);
    @(negedge clk);
    ready_in = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rstn     = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    data_in  = 32'h0;
    test_reset();
    test_steady_stream();
    test_fill_backpressure();
    test_stall_stability();
    test_push_pop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
